key_extract_cfg_tx: RTL and testbench

- Control-path packet transmitter that builds the 3-beat configuration packets consumed by a stage's key-extract control receiver.
- Takes one table-write request (key-offset or key-mask entry) and serialises it onto the 256-bit AXI-Stream control chain.
- Header fields and byte ordering are arranged so the receiver decodes them directly.
- Sits at the control-chain ingress, where software or a test harness programs the key-extract tables.

---
 rtl/key_extract_cfg_tx.sv | 145 ++++++++++++++
 tb/tb_key_extract_cfg_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_extract_cfg_tx.sv
// Serialises one key-extract table write into the 3-beat 256-bit control packet
// (constant header, routing header, byte-reversed payload) for the control chain.
module key_extract_cfg_tx #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int KEY_OFF              = 68,
  parameter int KEY_EX_ID            = 1,
  parameter int IPG                  = 2,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] HDR0 = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [4:0]                        req_stage,
  input  logic [3:0]                        req_sub_unit,
  input  logic                              req_type,
  input  logic [7:0]                        req_index,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    req_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       pkt_cnt
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int BYTES = DW / 8;
  localparam logic [2:0] MOD_TYPE = 3'(KEY_EX_ID);
  localparam logic [3:0] GAP_LAST = (IPG > 0) ? 4'(IPG - 1) : 4'd0;
  localparam logic [C_S_AXIS_TUSER_WIDTH-1:0] LEN_TUSER = C_S_AXIS_TUSER_WIDTH'(96);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, GAP} state_t;

  state_t state, next_state;
  logic [3:0] gap_cnt, gap_cnt_n;
  logic       accept, cnt_inc, beat_fire;

  logic [4:0]    stage_q;
  logic [3:0]    sub_q;
  logic          typ_q;
  logic [7:0]    idx_q;
  logic [DW-1:0] data_q;

  logic [DW-1:0] hdr_word, payload_p, payload_bus;
  logic [DW-1:0] tdata_n;
  logic          tvalid_n, tlast_n, ready_n;

  // NOTE: request fields carry no reset; they are only read after an accept loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      stage_q <= req_stage;
      sub_q   <= req_sub_unit;
      typ_q   <= req_type;
      idx_q   <= req_index;
      data_q  <= req_data;
    end
  end

  // Routing header and payload derived from the latched request.
  always_comb begin
    hdr_word             = '0;
    hdr_word[64 +: 16]   = 16'hF2F1;
    hdr_word[112 +: 8]   = {stage_q, MOD_TYPE};
    hdr_word[120 +: 4]   = {3'b000, typ_q};
    hdr_word[124 +: 4]   = sub_q;
    hdr_word[128 +: 8]   = idx_q;

    payload_p = '0;
    if (typ_q) payload_p = data_q;
    else       payload_p[DW-1 -: KEY_OFF] = data_q[KEY_OFF-1:0];

    payload_bus = '0;
    for (int k = 0; k < BYTES; k++)
      payload_bus[8*k +: 8] = payload_p[DW-1-8*k -: 8];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    gap_cnt_n  = '0;
    accept     = 1'b0;
    cnt_inc    = 1'b0;
    beat_fire  = m_axis_tvalid && m_axis_tready;

    case (state)
      IDLE:  if (req_valid && req_ready) begin
               next_state = BEAT0;
               accept     = 1'b1;
             end
      BEAT0: if (beat_fire) next_state = BEAT1;
      BEAT1: if (beat_fire) next_state = BEAT2;
      BEAT2: if (beat_fire) begin
               cnt_inc    = 1'b1;
               next_state = (IPG == 0) ? IDLE : GAP;
             end
      GAP:   if (gap_cnt == GAP_LAST) next_state = IDLE;
             else                     gap_cnt_n  = gap_cnt + 4'd1;
      default: next_state = IDLE;
    endcase

    // Outputs are registered, so they are computed for the state being entered.
    tdata_n = '0;
    tlast_n = 1'b0;
    case (next_state)
      BEAT0: tdata_n = HDR0;
      BEAT1: tdata_n = hdr_word;
      BEAT2: begin
        tdata_n = payload_bus;
        tlast_n = 1'b1;
      end
      default: ;
    endcase
    tvalid_n = (next_state == BEAT0) || (next_state == BEAT1) || (next_state == BEAT2);
    ready_n  = (next_state == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      req_ready     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pkt_cnt       <= '0;
    end else begin
      state         <= next_state;
      gap_cnt       <= gap_cnt_n;
      req_ready     <= ready_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tuser  <= tvalid_n ? LEN_TUSER : '0;
      m_axis_tkeep  <= tvalid_n ? '1 : '0;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      pkt_cnt       <= pkt_cnt + {31'd0, cnt_inc};
    end
  end

endmodule

// File: tb/tb_key_extract_cfg_tx.sv
// Bench for key_extract_cfg_tx: directed vector table, backpressure, spacing,
// async reset and counter wrap, plus random requests against a packet model.
module tb_key_extract_cfg_tx;

  localparam int IPG = 2;

  typedef struct {
    logic [4:0]   stage;
    logic [3:0]   sub;
    logic         typ;
    logic [7:0]   idx;
    logic [255:0] data;
  } req_t;

  typedef struct {
    req_t       req;
    int         mode;        // 0: always ready, 1: random ready, 2: 4-cycle stall on beat1
    logic [7:0] exp_mod;
    logic [3:0] exp_typ;
    logic [3:0] exp_sub;
    logic [7:0] exp_idx;
    logic [7:0] exp_byte0;
    logic [7:0] exp_byte1;
    logic [7:0] exp_byte31;
    logic       zero_hi;     // bytes 9..31 of the payload beat must be zero
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [4:0]   req_stage;
  logic [3:0]   req_sub_unit;
  logic         req_type;
  logic [7:0]   req_index;
  logic [255:0] req_data;
  logic [255:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [31:0]  pkt_cnt;

  key_extract_cfg_tx #(.IPG(IPG)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_stage     (req_stage),
    .req_sub_unit  (req_sub_unit),
    .req_type      (req_type),
    .req_index     (req_index),
    .req_data      (req_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Expected beat b of the packet for request r, built from field positions and byte order.
  function automatic logic [255:0] model_beat(input int b, input req_t r);
    logic [255:0] w, p;
    w = '0;
    case (b)
      0: w = '0;
      1: w = (256'hF2F1 << 64) | (256'({r.stage, 3'd1}) << 112) | (256'(r.typ) << 120)
           | (256'(r.sub) << 124) | (256'(r.idx) << 128);
      default: begin
        p = r.typ ? r.data : ((r.data & ((256'd1 << 68) - 256'd1)) << (256 - 68));
        for (int k = 0; k < 32; k++)
          w = w | (((p >> (8 * (31 - k))) & 256'hFF) << (8 * k));
      end
    endcase
    return w;
  endfunction

  task automatic wait_ready(input string name);
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check(name, req_ready, 1'b1);
  endtask

  // Present one request, collect its three beats and check them against the model.
  task automatic run_pkt(input req_t r, input int mode, output logic [2:0][255:0] cap);
    int           beats, cyc, stalls;
    logic [255:0] held;
    logic         held_last, held_v, tr;
    cap = '0; beats = 0; cyc = 0; stalls = 0;
    held = '0; held_last = 1'b0; held_v = 1'b0;
    req_stage = r.stage; req_sub_unit = r.sub; req_type = r.typ;
    req_index = r.idx;   req_data = r.data;    req_valid = 1'b1;
    wait_ready("accept_ready");
    @(negedge clk);
    req_valid = 1'b0;
    req_stage = ~r.stage; req_sub_unit = ~r.sub; req_type = ~r.typ;
    req_index = ~r.idx;   req_data = ~r.data;
    check("beat0_latency", m_axis_tvalid, 1'b1);
    while (beats < 3 && cyc < 60) begin
      if (mode == 1)                              tr = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && beats == 1 && stalls < 4) tr = 1'b0;
      else                                        tr = 1'b1;
      if (mode == 2 && !tr) stalls++;
      if (held_v)
        check("hold_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held_last, held});
      check("tvalid_in_pkt", m_axis_tvalid, 1'b1);
      if (m_axis_tvalid && tr) begin
        cap[beats] = m_axis_tdata;
        check($sformatf("beat%0d_data", beats), m_axis_tdata, model_beat(beats, r));
        check($sformatf("beat%0d_tlast", beats), m_axis_tlast, beats == 2);
        check("beat_side", {m_axis_tkeep, m_axis_tuser}, {32'hFFFF_FFFF, 128'd96});
        beats++;
      end
      held_v = m_axis_tvalid && !tr;
      held = m_axis_tdata;
      held_last = m_axis_tlast;
      m_axis_tready = tr;
      @(negedge clk);
      cyc++;
    end
    m_axis_tready = 1'b1;
    check("pkt_len", beats, 3);
    check("post_tvalid", m_axis_tvalid, 1'b0);
    if (mode == 2) check("bp_stalls", stalls, 4);
    exp_cnt = exp_cnt + 32'd1;
    check("pkt_cnt", pkt_cnt, exp_cnt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t              vecs[4];
    req_t              r;
    logic [2:0][255:0] cap;
    int                f0, t0, f1;
    logic              rr[16], tv[16];
    logic              prev_v;

    vecs[0] = '{req: '{5'd3, 4'd0, 1'b0, 8'd5, 256'h1_2345_6789_ABCD_EF01}, mode: 0,
                exp_mod: 8'h19, exp_typ: 4'd0, exp_sub: 4'd0, exp_idx: 8'd5,
                exp_byte0: 8'h12, exp_byte1: 8'h34, exp_byte31: 8'h00, zero_hi: 1'b1};
    vecs[1] = '{req: '{5'd31, 4'hA, 1'b1, 8'hFF,
                256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20}, mode: 0,
                exp_mod: 8'hF9, exp_typ: 4'd1, exp_sub: 4'hA, exp_idx: 8'hFF,
                exp_byte0: 8'h01, exp_byte1: 8'h02, exp_byte31: 8'h20, zero_hi: 1'b0};
    vecs[2] = '{req: '{5'd0, 4'hF, 1'b0, 8'h80, {256{1'b1}}}, mode: 1,
                exp_mod: 8'h01, exp_typ: 4'd0, exp_sub: 4'hF, exp_idx: 8'h80,
                exp_byte0: 8'hFF, exp_byte1: 8'hFF, exp_byte31: 8'h00, zero_hi: 1'b1};
    vecs[3] = '{req: '{5'd17, 4'd3, 1'b1, 8'h1F, (256'h80 << 248) | 256'h1}, mode: 2,
                exp_mod: 8'h89, exp_typ: 4'd1, exp_sub: 4'd3, exp_idx: 8'h1F,
                exp_byte0: 8'h80, exp_byte1: 8'h00, exp_byte31: 8'h01, zero_hi: 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_stage = '0; req_sub_unit = '0; req_type = 1'b0;
    req_index = '0; req_data = '0; m_axis_tready = 1'b0; exp_cnt = '0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_cnt", pkt_cnt, 32'd0);
    check("rst_bus", {m_axis_tdata, m_axis_tlast}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);
    m_axis_tready = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 4; i++) begin
      run_pkt(vecs[i].req, vecs[i].mode, cap);
      check($sformatf("v%0d_f2f1", i), cap[1][64 +: 16], 16'hF2F1);
      check($sformatf("v%0d_mod", i), cap[1][112 +: 8], vecs[i].exp_mod);
      check($sformatf("v%0d_typ", i), cap[1][120 +: 4], vecs[i].exp_typ);
      check($sformatf("v%0d_sub", i), cap[1][124 +: 4], vecs[i].exp_sub);
      check($sformatf("v%0d_idx", i), cap[1][128 +: 8], vecs[i].exp_idx);
      check($sformatf("v%0d_byte0", i), cap[2][7:0], vecs[i].exp_byte0);
      check($sformatf("v%0d_byte1", i), cap[2][15:8], vecs[i].exp_byte1);
      check($sformatf("v%0d_byte31", i), cap[2][255:248], vecs[i].exp_byte31);
      if (vecs[i].zero_hi) check($sformatf("v%0d_zero_hi", i), cap[2][255:72], '0);
    end

    // Random requests with random backpressure.
    for (int i = 0; i < 20; i++) begin
      r.stage = 5'($urandom); r.sub = 4'($urandom); r.typ = 1'($urandom);
      r.idx   = 8'($urandom);
      r.data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_pkt(r, 1, cap);
    end

    // Back-to-back with req_valid held high: check first-beat spacing and the gap.
    wait_ready("b2b_start");
    req_stage = 5'd9; req_sub_unit = 4'd2; req_type = 1'b0; req_index = 8'd7;
    req_data = 256'hDEAD_BEEF; req_valid = 1'b1; m_axis_tready = 1'b1;
    f0 = -1; t0 = -1; f1 = -1; prev_v = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rr[c] = req_ready;
      tv[c] = m_axis_tvalid;
      if (m_axis_tvalid && !prev_v) begin
        if (f0 < 0) f0 = c;
        else if (f1 < 0) f1 = c;
      end
      if (m_axis_tvalid && m_axis_tlast && t0 < 0) t0 = c;
      prev_v = m_axis_tvalid;
    end
    req_valid = 1'b0;
    check("b2b_first_beat", f0, 0);
    check("b2b_tlast_to_beat0", f1 - t0, 4);
    check("b2b_beat0_spacing", f1 - f0, 3 + IPG + 1);
    if (t0 >= 0 && t0 < 12) begin
      check("b2b_gap_ready", {rr[t0+1], rr[t0+2]}, 2'b00);
      check("b2b_gap_tvalid", {tv[t0+1], tv[t0+2], tv[t0+3]}, 3'b000);
    end else begin
      check("b2b_tlast_seen", t0, 2);
    end
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of beat1.
    wait_ready("rst_mid_start");
    req_stage = 5'd4; req_sub_unit = 4'd1; req_type = 1'b1; req_index = 8'd2;
    req_data = 256'h55; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_beat1", {m_axis_tvalid, m_axis_tdata[64 +: 16]}, {1'b1, 16'hF2F1});
    #2 rst = 1'b1;
    #1;
    check("rst_mid_tvalid", m_axis_tvalid, 1'b0);
    check("rst_mid_cnt", pkt_cnt, 32'd0);
    check("rst_mid_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    r = '{5'd6, 4'd5, 1'b0, 8'd12, 256'hF_0123_4567_89AB_CDEF};
    run_pkt(r, 0, cap);

    // Counter wrap.
    @(negedge clk);
    force dut.pkt_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_cnt;
    @(negedge clk);
    check("cnt_forced", pkt_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    r = '{5'd1, 4'd0, 1'b1, 8'd3, {8{32'hA5A5_5A5A}}};
    run_pkt(r, 0, cap);
    check("cnt_wrap", pkt_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
